jk_cmd_seq: RTL and testbench

- Command sequencer sitting directly upstream of the negedge JK flip-flop (jkff_negedge): accepts set/clear/toggle/hold commands on a valid/ready interface, buffers them in a small FIFO, and drives the FF's j/k inputs for a programmable number of cycles.
- Drives j/k from posedge registers, so they are stable at the FF's negedge sampling point.
- Keeps a reference model of the expected FF state, compares it against the FF's q fed back after each command, and flags mismatches.

---
 rtl/jk_cmd_seq_if.sv | 25 ++
 rtl/jk_cmd_seq.sv | 147 ++++++++++++++
 tb/tb_jk_cmd_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_seq_if.sv
// Command handshake bundle between a command source and jk_cmd_seq.
// Latency: none, wires only.
// Backpressure: the source holds cmd_valid/cmd_op/cmd_cnt until cmd_ready is seen high at a clock edge.
interface jk_cmd_seq_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_seq.sv
// Buffers JK commands and drives j/k for cmd_cnt cycles, checking the FF q against a model.
// Latency: push at t0 -> j/k at t1, done during t1+N, next command via IDLE afterwards.
// Backpressure: cmd_ready = !full; a flush drops any coincident push.
module jk_cmd_seq #(
    parameter int   DEPTH  = 4,
    parameter int   CNT_W  = 4,
    parameter logic INIT_Q = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    jk_cmd_seq_if.slave    cmd,
    input  logic           flush,
    input  logic           q_fb,
    output logic           j,
    output logic           k,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           exp_q
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]       op_mem  [DEPTH];
    logic [CNT_W-1:0] cnt_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] rem;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    // JK rule applied once for the negedge that has just been driven.
    function automatic logic jk_next(input logic q, input logic [1:0] op);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign cmd.cmd_ready = !full;
    assign push          = cmd.cmd_valid && !full && !flush;
    assign pop           = (state == IDLE) && !empty && !flush;
    assign head_op       = op_mem[rd_ptr];
    // A zero count means a single cycle, so rem is never loaded with 0.
    assign head_cnt      = (cnt_mem[rd_ptr] == '0) ? CNT_W'(1) : cnt_mem[rd_ptr];
    assign busy          = (state != IDLE);
    assign done          = (state == CHECK);

    // Command storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= cmd.cmd_op;
            cnt_mem[wr_ptr] <= cmd.cmd_cnt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: registered j/k drive, expected-q model and sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= 2'b00;
            rem   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
            exp_q <= INIT_Q;
            err   <= 1'b0;
        end else if (flush) begin
            // The negedge just passed was really driven, so the model still accounts for it.
            if (state == DRIVE) exp_q <= jk_next(exp_q, op_r);
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        op_r  <= head_op;
                        rem   <= head_cnt;
                        j     <= head_op[1];
                        k     <= head_op[0];
                        state <= DRIVE;
                    end else begin
                        j <= 1'b0;
                        k <= 1'b0;
                    end
                end
                DRIVE: begin
                    exp_q <= jk_next(exp_q, op_r);
                    if (rem <= CNT_W'(1)) begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= CHECK;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                CHECK: begin
                    if (q_fb != exp_q) err <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq with a behavioural negedge JK FF in the loop.
// Expected per-command results are queued at acceptance and checked when done pulses.
module tb_jk_cmd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic force_en = 1'b0;
    logic ff_q;
    logic q_fb;
    logic j, k, busy, done, err, exp_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        int         n;
        logic       q;
        logic       e;
    } sb_t;

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        int         n;
        logic       q;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[10];
    logic model_q;
    logic model_e;

    always #5 clk = ~clk;

    jk_cmd_seq_if #(.CNT_W(4)) cif();

    jk_cmd_seq #(.DEPTH(4), .CNT_W(4), .INIT_Q(1'b0)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .flush (flush),
        .q_fb  (q_fb),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .exp_q (exp_q)
    );

    // Downstream negedge JK flip-flop
    always @(negedge clk or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_fb = force_en ? 1'b1 : ff_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic logic model(input logic q, input logic [1:0] op, input int n);
        logic r = q;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b01:   r = 1'b0;
                2'b10:   r = 1'b1;
                2'b11:   r = ~r;
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Monitor: counts DRIVE cycles, checks j/k against the executing op, scores on done.
    int   drv_cnt = 0;
    logic jk_bad = 1'b0;
    logic err_pend = 1'b0;
    logic err_want = 1'b0;
    always @(negedge clk) begin
        if (rst || flush) begin
            drv_cnt  = 0;
            jk_bad   = 1'b0;
            err_pend = 1'b0;
        end else begin
            if (err_pend) begin
                chk("err_after_done", {31'd0, err}, {31'd0, err_want});
                err_pend = 1'b0;
            end
            if (busy && !done) begin
                drv_cnt++;
                if (sb_q.size() == 0 || {j, k} !== sb_q[0].op) jk_bad = 1'b1;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("done_without_command", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("drive_cycles", drv_cnt, e.n);
                    chk("jk_during_drive", {31'd0, jk_bad}, 32'd0);
                    chk("jk_zero_in_check", {30'd0, j, k}, 32'd0);
                    chk("exp_q_at_done", {31'd0, exp_q}, {31'd0, e.q});
                    err_want = e.e;
                    err_pend = 1'b1;
                end
                drv_cnt = 0;
                jk_bad  = 1'b0;
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [3:0] cnt, input int n,
                        input logic q, input logic e, output int stalls);
        stalls = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_cnt   = cnt;
        while (!cif.cmd_ready && stalls < 500) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 500) begin
            chk("push_timeout", 32'd1, 32'd0);
            cif.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb_q.push_back('{op, n, q, e});
            #1 cif.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", {31'd0, (n < 3000)}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_within_budget", {31'd0, (n < 100)}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int busy_seen;
        tbl[0] = '{2'b10, 4'd1,  1,  1'b1};
        tbl[1] = '{2'b11, 4'd3,  3,  1'b0};
        tbl[2] = '{2'b01, 4'd0,  1,  1'b0};
        tbl[3] = '{2'b00, 4'd2,  2,  1'b0};
        tbl[4] = '{2'b11, 4'd1,  1,  1'b1};
        tbl[5] = '{2'b00, 4'd0,  1,  1'b1};
        tbl[6] = '{2'b11, 4'd15, 15, 1'b0};
        tbl[7] = '{2'b10, 4'd2,  2,  1'b1};
        tbl[8] = '{2'b01, 4'd2,  2,  1'b0};
        tbl[9] = '{2'b11, 4'd4,  4,  1'b0};

        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_cnt   = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_j", {31'd0, j}, 32'd0);
        chk("rst_k", {31'd0, k}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_exp_q", {31'd0, exp_q}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cif.cmd_ready}, 32'd1);

        // First command: cycle-accurate latency of set cnt=1
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b10;
        cif.cmd_cnt   = 4'd1;
        sb_q.push_back('{2'b10, 1, 1'b1, 1'b0});
        @(posedge clk);
        #1 cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_t0_j", {31'd0, j}, 32'd0);
        chk("lat_t0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("lat_t1_jk", {30'd0, j, k}, 32'd2);
        chk("lat_t1_busy", {31'd0, busy}, 32'd1);
        chk("lat_t1_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("lat_t2_done", {31'd0, done}, 32'd1);
        chk("lat_t2_busy", {31'd0, busy}, 32'd1);
        chk("lat_t2_exp_q", {31'd0, exp_q}, 32'd1);
        @(negedge clk);
        chk("lat_t3_done", {31'd0, done}, 32'd0);
        chk("lat_t3_busy", {31'd0, busy}, 32'd0);
        chk("lat_t3_q_fb", {31'd0, q_fb}, 32'd1);

        // Table of commands from exp_q = 0, pushed back to back
        sb_q.push_back('{2'b01, 1, 1'b0, 1'b0});
        sb_q.delete();
        push(2'b01, 4'd1, 1, 1'b0, 1'b0, st);
        wait_idle();
        for (int i = 0; i < 10; i++) push(tbl[i].op, tbl[i].cnt, tbl[i].n, tbl[i].q, 1'b0, st);
        wait_idle();
        chk("table_final_exp_q", {31'd0, exp_q}, {31'd0, tbl[9].q});
        model_q = tbl[9].q;
        model_e = 1'b0;

        // Backpressure: one long command in DRIVE, then five more held valid
        model_q = model(model_q, 2'b11, 8);
        push(2'b11, 4'd8, 8, model_q, model_e, st);
        wait_busy();
        model_q = model(model_q, 2'b10, 1);
        push(2'b10, 4'd1, 1, model_q, model_e, st);
        chk("bp_stall_b", st, 0);
        model_q = model(model_q, 2'b00, 3);
        push(2'b00, 4'd3, 3, model_q, model_e, st);
        chk("bp_stall_c", st, 0);
        model_q = model(model_q, 2'b11, 2);
        push(2'b11, 4'd2, 2, model_q, model_e, st);
        chk("bp_stall_d", st, 0);
        model_q = model(model_q, 2'b01, 1);
        push(2'b01, 4'd1, 1, model_q, model_e, st);
        chk("bp_stall_e", st, 0);
        @(negedge clk);
        chk("bp_ready_full", {31'd0, cif.cmd_ready}, 32'd0);
        model_q = model(model_q, 2'b11, 3);
        push(2'b11, 4'd3, 3, model_q, model_e, st);
        chk("bp_stall_f", {31'd0, (st > 0)}, 32'd1);
        wait_idle();
        chk("bp_final_exp_q", {31'd0, exp_q}, {31'd0, model_q});

        // Mismatch: q_fb forced high while the model expects 0
        force_en = 1'b1;
        model_q = 1'b0;
        model_e = 1'b1;
        push(2'b01, 4'd1, 1, model_q, model_e, st);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("err_done_seen", {31'd0, (n < 100)}, 32'd1);
        end
        @(negedge clk);
        force_en = 1'b0;
        model_q = model(model_q, 2'b10, 2);
        push(2'b10, 4'd2, 2, model_q, model_e, st);
        wait_idle();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of toggle cnt=5 with two more queued
        push(2'b11, 4'd5, 5, model(model_q, 2'b11, 5), model_e, st);
        push(2'b00, 4'd1, 1, 1'b0, model_e, st);
        push(2'b01, 4'd1, 1, 1'b0, model_e, st);
        wait_busy();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_jk", {30'd0, j, k}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_exp_q", {31'd0, exp_q}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_q = 1'b0;
        model_e = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("rst_fifo_empty", busy_seen, 0);

        // Flush with three queued commands and a coincident push
        push(2'b10, 4'd6, 6, 1'b1, 1'b0, st);
        push(2'b00, 4'd2, 2, 1'b1, 1'b0, st);
        push(2'b11, 4'd1, 1, 1'b0, 1'b0, st);
        push(2'b01, 4'd3, 3, 1'b0, 1'b0, st);
        wait_busy();
        repeat (3) @(negedge clk);
        flush = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b11;
        cif.cmd_cnt   = 4'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_jk", {30'd0, j, k}, 32'd0);
        chk("flush_exp_q_kept", {31'd0, exp_q}, 32'd1);
        chk("flush_ready", {31'd0, cif.cmd_ready}, 32'd1);
        sb_q.delete();
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("flush_fifo_empty", busy_seen, 0);
        push(2'b11, 4'd2, 2, 1'b1, 1'b0, st);
        wait_idle();
        chk("after_flush_err", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
